opb_read_sequencer: RTL



---
 rtl/opb_read_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/opb_read_sequencer.sv
// opb_read_sequencer
// Byte-wise flash read sequencer feeding the flash output mux/register stage.
// Each byte: one flash read strobe, a fixed access-latency wait, then the byte
// is steered either to off-chip SRAM (write strobe, auto-incrementing
// address) or into the mux output register followed by an RX FIFO push.
module opb_read_sequencer #(
  parameter int LEN_W     = 9,
  parameter int ADDR_W    = 8,
  parameter int FLASH_LAT = 2
) (
  input  logic              clk2,
  input  logic              NReset,
  input  logic              start_read,
  input  logic              dest_sram,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic [ADDR_W-1:0] sram_base,
  input  logic              abort,
  input  logic              fifo_full,
  output logic              flash_re,
  output logic              OPB_outputshift,
  output logic              Output_control,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              fifo_push,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    PUSH    = 3'd5,
    DONE    = 3'd6
  } state_t;

  // WAIT spans FLASH_LAT-1 cycles: the counter is loaded with FLASH_LAT-2 and
  // the last WAIT cycle is the one that sees zero.
  localparam logic [2:0] WAIT_LOAD = 3'((FLASH_LAT > 1) ? (FLASH_LAT - 2) : 0);

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic              dest;
  logic [2:0]        lat_cnt;

  // Stall condition: only the FIFO path is held back by a full RX FIFO.
  logic fifo_stall;
  assign fifo_stall = !dest && fifo_full;

  // Transfer state machine, latched command and SRAM address pointer.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state          <= IDLE;
      remaining      <= '0;
      dest           <= 1'b0;
      sram_addr      <= '0;
      lat_cnt        <= '0;
      Output_control <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Cancel wins over every other transition; any in-flight byte is dropped.
      state          <= IDLE;
      lat_cnt        <= '0;
      Output_control <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_read) begin
            dest           <= dest_sram;
            remaining      <= byte_count;
            sram_addr      <= sram_base;
            Output_control <= dest_sram;
            state          <= SETUP;
          end
        end
        SETUP: begin
          state <= (remaining == '0) ? DONE : ISSUE;
        end
        ISSUE: begin
          if (!fifo_stall) begin
            if (FLASH_LAT > 1) begin
              lat_cnt <= WAIT_LOAD;
              state   <= WAIT;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd0) begin
            state <= CAPTURE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        CAPTURE: begin
          remaining <= remaining - LEN_W'(1);
          if (dest) begin
            sram_addr <= sram_addr + ADDR_W'(1);
            state     <= (remaining == LEN_W'(1)) ? DONE : ISSUE;
          end else begin
            state <= PUSH;
          end
        end
        PUSH: begin
          state <= (remaining == '0) ? DONE : ISSUE;
        end
        DONE: begin
          state          <= IDLE;
          Output_control <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode from the state register; fifo_full only gates the read strobe.
  assign flash_re        = (state == ISSUE) && !fifo_stall;
  assign sram_we         = (state == CAPTURE) && dest;
  assign OPB_outputshift = (state == CAPTURE) && !dest;
  assign fifo_push       = (state == PUSH);
  assign done            = (state == DONE);
  assign busy            = (state != IDLE);

endmodule
